// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller: arbitrates load-use, EX redirect, memory wait and halt/drain.
// Optional statistics counters are enabled with `define PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
  parameter int REG_AW       = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              halt_req,
  output logic              pc_we,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              stall_flg,
  output logic              halted,
  output logic              mem_err,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e         state_q, state_d, eff_state;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           mem_err_q, mem_err_d;
  logic           luh, mem_stall;
  logic           pc_we_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
  logic           exmem_en_c, stall_flg_c, halted_c;

  assign luh = ex_memread & ((id_uses_rs & (id_rs == ex_rd)) |
                             (id_uses_rt & (id_rt == ex_rd)));
  assign mem_stall = mem_req & ~mem_ack;

  // Dropping halt_req mid-drain resumes normal operation in that very cycle.
  assign eff_state = (state_q == DRAIN && !halt_req) ? RUN : state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    mem_err_d    = mem_err_q;
    pc_we_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_en_c    = 1'b0;
    idex_flush_c = 1'b0;
    exmem_en_c   = 1'b0;
    stall_flg_c  = 1'b0;
    halted_c     = 1'b0;
    unique case (eff_state)
      RUN: begin
        state_d = RUN;
        if (mem_stall) begin
          state_d    = MWAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (ex_redirect) begin
          pc_we_c      = 1'b1;
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          idex_en_c    = 1'b1;
          idex_flush_c = 1'b1;
          exmem_en_c   = 1'b1;
          stall_flg_c  = 1'b1;
        end else if (luh) begin
          idex_en_c    = 1'b1;
          idex_flush_c = 1'b1;
          exmem_en_c   = 1'b1;
          stall_flg_c  = 1'b1;
        end else begin
          pc_we_c    = 1'b1;
          ifid_en_c  = 1'b1;
          idex_en_c  = 1'b1;
          exmem_en_c = 1'b1;
          if (halt_req) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      MWAIT: begin
        if (mem_ack) begin
          state_d = RUN;
        end else if (wait_cnt_q >= WAIT_MAX) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          idex_en_c    = 1'b1;
          idex_flush_c = 1'b1;
          exmem_en_c   = 1'b1;
          stall_flg_c  = 1'b1;
          if (drain_cnt_q >= DRAIN_LAST) begin
            state_d = HALTED;
          end else if (drain_cnt_q != '1) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      HALTED: begin
        halted_c = 1'b1;
        if (!halt_req) state_d = RUN;
      end
    endcase
  end

  // Reset forces every control low immediately, independent of the clock.
  assign pc_we      = pc_we_c      & ~rst;
  assign ifid_en    = ifid_en_c    & ~rst;
  assign ifid_flush = ifid_flush_c & ~rst;
  assign idex_en    = idex_en_c    & ~rst;
  assign idex_flush = idex_flush_c & ~rst;
  assign exmem_en   = exmem_en_c   & ~rst;
  assign stall_flg  = stall_flg_c  & ~rst;
  assign halted     = halted_c     & ~rst;
  assign mem_err    = mem_err_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        frozen, redirect_acc;

  assign frozen       = ~(pc_we | ifid_en | idex_en | exmem_en);
  assign redirect_acc = (eff_state == RUN) & ~mem_stall & ex_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_flg | frozen) && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redirect_acc && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle vector table plus multi-cycle
// sequences for memory wait, halt/drain, timeout and asynchronous reset.
module tb_pipe_ctrl;

  logic        clk, rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_memread, ex_redirect;
  logic        mem_req, mem_ack, halt_req;
  logic        pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic        stall_flg, halted, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks;
  int n_fail;

  // {pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, stall_flg}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_LUH    = 7'b0001111;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_FROZEN = 7'b0000000;

  logic [6:0] ctrl;
  assign ctrl = {pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, stall_flg};

  pipe_ctrl #(.REG_AW(3), .MEM_TIMEOUT(15), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req),
    .pc_we(pc_we), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .stall_flg(stall_flg), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rs, rt, rd;
    logic       urs, urt, memread, redirect, mreq, mack;
    logic [6:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                              input logic urs, input logic urt, input logic memread,
                              input logic redirect, input logic mreq, input logic mack,
                              input logic [6:0] exp_ctrl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.urs = urs; v.urt = urt; v.memread = memread;
    v.redirect = redirect; v.mreq = mreq; v.mack = mack;
    v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    halt_req = 1'b0;
    rst = 1'b0;

    vecs[0] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    vecs[1] = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LUH);
    vecs[2] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    vecs[3] = mk(3'd1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LUH);
    vecs[4] = mk(3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
    vecs[5] = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    vecs[6] = mk(3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_REDIR);
    vecs[7] = mk(3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_REDIR);
    vecs[8] = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN);
    vecs[9] = mk(3'd2, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);

    // Reset values while rst is held
    #2 rst = 1'b1;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_FROZEN));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_counters", {stall_cnt, flush_cnt}, 32'd0);
    next_cyc();
    rst = 1'b0;

    // Single-cycle hazard/redirect vectors, all applied from RUN
    for (int i = 0; i < 10; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      ex_memread = vecs[i].memread; ex_redirect = vecs[i].redirect;
      mem_req = vecs[i].mreq; mem_ack = vecs[i].mack;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      next_cyc();
    end
    idle_inputs();

    // Statistics: accepted redirect bumps flush_cnt from 0 to 1
    rst = 1'b1;
    #1 rst = 1'b0;
    id_rs = 3'd3; ex_rd = 3'd3; id_uses_rs = 1'b1; ex_memread = 1'b1; ex_redirect = 1'b1;
    @(negedge clk);
    chk("stats_flush_before", 32'(flush_cnt), 32'd0);
    next_cyc();
    idle_inputs();
    @(negedge clk);
`ifdef PIPE_CTRL_STATS_EN
    chk("stats_flush_after", 32'(flush_cnt), 32'd1);
    chk("stats_stall_after", 32'(stall_cnt), 32'd1);
`else
    chk("stats_flush_tied", 32'(flush_cnt), 32'd0);
    chk("stats_stall_tied", 32'(stall_cnt), 32'd0);
`endif
    next_cyc();

    // Memory wait: 4 cycles without ack then ack -> 5 frozen cycles
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mwait_frozen%0d", k), 32'(ctrl), 32'(C_FROZEN));
      next_cyc();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("mwait_ack_frozen", 32'(ctrl), 32'(C_FROZEN));
    next_cyc();
    idle_inputs();
    @(negedge clk);
    chk("mwait_resume", 32'(ctrl), 32'(C_RUN));
    chk("mwait_no_err", 32'(mem_err), 32'd0);
    next_cyc();

    // Halt: one normal cycle, 3 bubbles, then halted until release
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_accept_ctrl", 32'(ctrl), 32'(C_RUN));
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drain_bubble%0d", k), {31'd0, halted}, 32'd0);
      chk($sformatf("drain_ctrl%0d", k), 32'(ctrl), 32'(C_LUH));
      next_cyc();
    end
    @(negedge clk);
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_ctrl", 32'(ctrl), 32'(C_FROZEN));
    next_cyc();
    halt_req = 1'b0;
    @(negedge clk);
    chk("halted_release_cycle", 32'(halted), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("halt_resume_flag", 32'(halted), 32'd0);
    chk("halt_resume_ctrl", 32'(ctrl), 32'(C_RUN));
    next_cyc();

    // Timeout: mem_err rises after 15 MWAIT cycles and stays set
    mem_req = 1'b1; mem_ack = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("timeout_not_yet", 32'(mem_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("timeout_set", 32'(mem_err), 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("timeout_sticky", 32'(mem_err), 32'd1);
    chk("timeout_rewait_frozen", 32'(ctrl), 32'(C_FROZEN));

    // Async reset between edges, mid-MWAIT
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_err", 32'(mem_err), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl), 32'(C_FROZEN));
    #1 rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("post_rst_mem_err", 32'(mem_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the NanoQuarter pipeline. It drives enable, flush and bubble controls for the PC, the IF/ID register, the ID/EX register (Stage 1) and the EX/MEM register. It arbitrates four sources: load-use hazards, EX-stage redirects (taken branch or jump), data-memory wait states and an external halt/drain request. It also drives the `stall_flg` field carried down the pipeline.

## Interface
Parameters:
- `REG_AW`, 3 — register index width.
- `MEM_TIMEOUT`, 15 — maximum consecutive cycles waiting for `mem_ack` before the error abort.
- `DRAIN_CYCLES`, 3 — number of bubble cycles injected before reporting halted.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk` in 1 — clock.
- `rst` in 1 — async active-high reset.
- `id_rs`, `id_rt` in `REG_AW` — source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 — the ID instruction reads `rs` / `rt`.
- `ex_rd` in `REG_AW` — destination register of the instruction in EX.
- `ex_memread` in 1 — the EX instruction is a load.
- `ex_redirect` in 1 — taken branch or jump resolved in EX this cycle.
- `mem_req` in 1 — the MEM-stage instruction is a load or store.
- `mem_ack` in 1 — data memory completes the access this cycle.
- `halt_req` in 1 — level request to drain and freeze the pipeline.
- `pc_we` out 1 — PC update enable.
- `ifid_en`, `ifid_flush` out 1 — IF/ID hold / bubble controls.
- `idex_en`, `idex_flush` out 1 — ID/EX (Stage 1) hold / bubble controls.
- `exmem_en` out 1 — EX/MEM hold control.
- `stall_flg` out 1 — drives Stage 1 `stall_flg_in`; high whenever a bubble is inserted into ID/EX.
- `halted` out 1 — pipeline drained and frozen.
- `mem_err` out 1 — sticky; set on memory timeout.
- `stall_cnt`, `flush_cnt` out 16 — statistics counters (see Configuration).

## Operation
- FSM states: `RUN`, `MWAIT`, `DRAIN`, `HALTED`. 2-bit state register.
- Control outputs are combinational from the current state and current inputs.
- Load-use hazard: `luh = ex_memread & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- `RUN` priority, highest first:
  - `mem_req & ~mem_ack`: freeze everything. All enables are 0, no flush. Go to `MWAIT` and load the wait counter with 1.
  - `ex_redirect`: `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, `stall_flg`=1. This gives two bubbles. Any `luh` this cycle is ignored.
  - `luh`: `pc_we`=0, `ifid_en`=0, `idex_flush`=1, `stall_flg`=1, `exmem_en`=1. This gives one bubble.
  - `halt_req`: go to `DRAIN` and load the drain counter with 0. This cycle proceeds as a normal run.
  - Otherwise all enables are 1 and all flushes are 0.
- `MWAIT`:
  - All enables are 0.
  - On `mem_ack`, return to `RUN`. Enables stay 0 in the ack cycle; the pipeline advances on the next edge from `RUN`.
  - Each cycle without `mem_ack`, the wait counter increments.
  - When the counter reaches `MEM_TIMEOUT`, set `mem_err` and return to `RUN`. The access is abandoned.
  - `mem_err` clears only on reset.
- `DRAIN`:
  - `pc_we`=0, `ifid_en`=0.
  - `idex_flush`=1, `stall_flg`=1, `exmem_en`=1.
  - Memory waits take precedence: if `mem_req & ~mem_ack`, all enables are 0 and the drain counter holds.
  - The counter increments per advancing cycle. At `DRAIN_CYCLES`-1 it goes to `HALTED`.
  - `ex_redirect` during `DRAIN` is ignored; the PC is frozen.
- `HALTED`:
  - All enables are 0 and `halted`=1.
  - When `halt_req` deasserts, go to `RUN` the next cycle.
- `halt_req` deasserted during `DRAIN`: go to `RUN` immediately. Bubbles already inserted remain in the pipeline.
- Counter widths: wait counter is `$clog2(MEM_TIMEOUT+1)` bits; drain counter is `$clog2(DRAIN_CYCLES+1)` bits. Both saturate and never wrap.

## Timing
- Reset (async, takes effect immediately):
  - state = `RUN`, counters = 0.
  - While `rst`=1: all enables and flushes are 0, `stall_flg`=0, `halted`=0, `mem_err`=0, `stall_cnt`=`flush_cnt`=0.
- Hazard and redirect responses are same-cycle (zero latency). State changes take effect at the next `clk` rising edge.
- Load-use costs exactly 1 cycle. Redirect costs exactly 2 bubbles. A memory wait of N cycles without ack costs N+1 frozen cycles, including the ack cycle.
- Simultaneous `ex_redirect` and `luh` in `RUN`: redirect only. Simultaneous memory wait and redirect: the wait wins, and the redirect is re-evaluated after the ack (the EX instruction is held).
- Reset asserted mid-`MWAIT` or mid-`DRAIN` aborts to `RUN` with no residual stall.

## Configuration
- `PIPE_CTRL_STATS_EN` defined:
  - `stall_cnt` increments on every cycle with `stall_flg`=1 or any frozen cycle.
  - `flush_cnt` increments on every `ex_redirect` cycle accepted in `RUN`.
  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
- Not defined: counter logic is omitted and both outputs are tied to 16'h0000.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=3, `id_rs`=3, `id_uses_rs`=1 → one cycle with `pc_we`=0, `ifid_en`=0, `idex_flush`=1, `stall_flg`=1; next cycle all enables are 1.
- Redirect plus hazard: `ex_redirect`=1 with `luh`=1 in the same cycle → `pc_we`=1, `ifid_flush`=1, `idex_flush`=1; with stats enabled, `flush_cnt` goes from 0 to 1.
- Memory wait: `mem_req`=1, `mem_ack` low for 4 cycles then high → enables are 0 for 5 cycles, state returns to `RUN`, `mem_err`=0.
- Timeout: `mem_req`=1, `mem_ack`=0 held, `MEM_TIMEOUT`=15 → `mem_err` rises after 15 `MWAIT` cycles, stays high, and clears only on `rst`.
- Halt: pulse `halt_req` high and hold, `DRAIN_CYCLES`=3 → 3 bubble cycles, then `halted`=1 with all enables 0; deassert `halt_req` → `RUN` the next cycle and `halted`=0.
- Async reset: assert `rst` mid-`MWAIT` between clock edges → outputs go to their reset values immediately, and after release the state is `RUN` with all enables 1.
